// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_2m
//  Brief    : Two-master to one-slave Wishbone classic arbiter with per-cycle
//             round-robin grant and a watchdog that ends stuck transfers with ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m #(
    parameter int WISHBONE_ADDR_WIDTH = 32,
    parameter int WISHBONE_BUS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                              CLK_I,
    input  logic                              RST_NI,

    input  logic                              M0_CYC_I,
    input  logic                              M0_STB_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]    M0_ADR_I,
    input  logic                              M0_WE_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     M0_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]   M0_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]     M0_DAT_O,
    output logic                              M0_ACK_O,
    output logic                              M0_ERR_O,

    input  logic                              M1_CYC_I,
    input  logic                              M1_STB_I,
    input  logic [WISHBONE_ADDR_WIDTH-1:0]    M1_ADR_I,
    input  logic                              M1_WE_I,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_I,
    input  logic [WISHBONE_BUS_WIDTH/8-1:0]   M1_SEL_I,
    output logic [WISHBONE_BUS_WIDTH-1:0]     M1_DAT_O,
    output logic                              M1_ACK_O,
    output logic                              M1_ERR_O,

    output logic                              S_CYC_O,
    output logic                              S_STB_O,
    output logic                              S_WE_O,
    output logic [WISHBONE_ADDR_WIDTH-1:0]    S_ADR_O,
    output logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_O,
    output logic [WISHBONE_BUS_WIDTH/8-1:0]   S_SEL_O,
    input  logic [WISHBONE_BUS_WIDTH-1:0]     S_DAT_I,
    input  logic                              S_ACK_I,
    input  logic                              S_ERR_I,

    output logic [1:0]                        GRANT_O,
    output logic                              TIMEOUT_O
);

    localparam int c_sel_w = WISHBONE_BUS_WIDTH / 8;
    // A disabled watchdog still needs a legal one-bit counter.
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_limit = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic c_wdog_en = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_last;
    logic [c_cnt_w-1:0]   r_wdog_cnt;

    logic                           w_gnt0;
    logic                           w_gnt1;
    logic                           w_sel_cyc;
    logic                           w_sel_stb;
    logic                           w_sel_we;
    logic [WISHBONE_ADDR_WIDTH-1:0] w_sel_adr;
    logic [WISHBONE_BUS_WIDTH-1:0]  w_sel_dat;
    logic [c_sel_w-1:0]             w_sel_sel;
    logic                           w_timeout;
    logic [c_cnt_w-1:0]             w_wdog_cnt_next;

    assign w_gnt0 = (r_state == GNT0);
    assign w_gnt1 = (r_state == GNT1);

    always_comb begin
        w_sel_cyc = 1'b0;
        w_sel_stb = 1'b0;
        w_sel_we  = 1'b0;
        w_sel_adr = '0;
        w_sel_dat = '0;
        w_sel_sel = '0;
        if (w_gnt0) begin
            w_sel_cyc = M0_CYC_I;
            w_sel_stb = M0_STB_I;
            w_sel_we  = M0_WE_I;
            w_sel_adr = M0_ADR_I;
            w_sel_dat = M0_DAT_I;
            w_sel_sel = M0_SEL_I;
        end else if (w_gnt1) begin
            w_sel_cyc = M1_CYC_I;
            w_sel_stb = M1_STB_I;
            w_sel_we  = M1_WE_I;
            w_sel_adr = M1_ADR_I;
            w_sel_dat = M1_DAT_I;
            w_sel_sel = M1_SEL_I;
        end
    end

    // A real ACK or ERR in the limit cycle takes precedence over the watchdog.
    assign w_timeout = c_wdog_en && w_sel_stb && !S_ACK_I && !S_ERR_I
                       && (r_wdog_cnt == c_cnt_limit);

    always_comb begin
        w_wdog_cnt_next = '0;
        if (c_wdog_en && w_sel_stb && !S_ACK_I && !S_ERR_I && !w_timeout) begin
            w_wdog_cnt_next = r_wdog_cnt + 1'b1;
        end
    end

    assign S_CYC_O   = w_sel_cyc;
    assign S_STB_O   = w_sel_stb & ~w_timeout;
    assign S_WE_O    = w_sel_we;
    assign S_ADR_O   = w_sel_adr;
    assign S_DAT_O   = w_sel_dat;
    assign S_SEL_O   = w_sel_sel;

    assign M0_ACK_O  = w_gnt0 & S_ACK_I;
    assign M0_ERR_O  = w_gnt0 & (S_ERR_I | w_timeout);
    assign M0_DAT_O  = w_gnt0 ? S_DAT_I : '0;
    assign M1_ACK_O  = w_gnt1 & S_ACK_I;
    assign M1_ERR_O  = w_gnt1 & (S_ERR_I | w_timeout);
    assign M1_DAT_O  = w_gnt1 ? S_DAT_I : '0;

    assign GRANT_O   = {w_gnt1, w_gnt0};
    assign TIMEOUT_O = w_timeout;

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_next;
            case (r_state)
                IDLE: begin
                    if (M0_CYC_I && (!M1_CYC_I || r_last)) begin
                        r_state    <= GNT0;
                        r_last     <= 1'b0;
                        r_wdog_cnt <= '0;
                    end else if (M1_CYC_I) begin
                        r_state    <= GNT1;
                        r_last     <= 1'b1;
                        r_wdog_cnt <= '0;
                    end
                end
                GNT0: begin
                    // Hand straight over to a waiting master; no idle cycle.
                    if (!M0_CYC_I) begin
                        r_wdog_cnt <= '0;
                        if (M1_CYC_I) begin
                            r_state <= GNT1;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                GNT1: begin
                    if (!M1_CYC_I) begin
                        r_wdog_cnt <= '0;
                        if (M0_CYC_I) begin
                            r_state <= GNT0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wdog_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
